// File: rtl/add_execution_unit.sv
// rtl/add_execution_unit.sv - multi-cycle 8-bit add/subtract unit with CDB request/grant broadcast
module add_execution_unit #(
    parameter int DATA_W    = 8,
    parameter int TAG_W     = 3,
    parameter int EX_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AR_Status,
    input  logic [DATA_W-1:0] AR_Out_Operand1,
    input  logic [DATA_W-1:0] AR_Out_Operand2,
    input  logic [TAG_W-1:0]  AR_Tag,
    input  logic              AR_Op,
    output logic              ADD_Status,
    output logic              CDB_Req,
    input  logic              CDB_Grant,
    output logic              CDB_Valid,
    output logic [DATA_W-1:0] CDB_Data,
    output logic [TAG_W-1:0]  CDB_Tag,
    output logic              ADD_Ovf
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_CDB} state_t;

    localparam logic [2:0] CNT_INIT = 3'(EX_CYCLES - 1);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                op_q, op_d, ovf_q, ovf_d;

    logic                accept;
    logic                exec_done;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_ovf;

    // Tag 0 means "no producer", so a dispatch carrying it is never a real instruction.
    assign accept    = (state_q == IDLE) && AR_Status && (AR_Tag != '0);
    assign exec_done = (state_q == EXEC) && (cnt_q == 3'd0);

    always_comb begin
        alu_res = op_q ? (a_q - b_q) : (a_q + b_q);
        // Overflow is only possible when the effective operand signs agree.
        if (op_q)
            alu_ovf = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) & (alu_res[DATA_W-1] ^ a_q[DATA_W-1]);
        else
            alu_ovf = ~(a_q[DATA_W-1] ^ b_q[DATA_W-1]) & (alu_res[DATA_W-1] ^ a_q[DATA_W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            tag_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = EXEC;
            EXEC:     if (exec_done) state_d = WAIT_CDB;
            WAIT_CDB: if (CDB_Grant) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        tag_d = tag_q;
        res_d = res_q;
        ovf_d = ovf_q;
        if (accept) begin
            cnt_d = CNT_INIT;
            a_d   = AR_Out_Operand1;
            b_d   = AR_Out_Operand2;
            op_d  = AR_Op;
            tag_d = AR_Tag;
        end
        if (state_q == EXEC && cnt_q != 3'd0)
            cnt_d = cnt_q - 3'd1;
        if (exec_done) begin
            res_d = alu_res;
            ovf_d = alu_ovf;
        end
    end

    // Bus outputs are zero unless broadcasting so several units can share a wired-OR CDB.
    always_comb begin
        ADD_Status = (state_q != IDLE);
        CDB_Req    = (state_q == WAIT_CDB);
        CDB_Valid  = CDB_Req & CDB_Grant;
        CDB_Data   = CDB_Valid ? res_q : '0;
        CDB_Tag    = CDB_Valid ? tag_q : '0;
        ADD_Ovf    = CDB_Valid & ovf_q;
    end

endmodule
